thor2023_icache_array: RTL

// Set-associative instruction-cache storage and tag-compare stage sitting between the fetch PC and the I$ refill controller.

---
 rtl/thor2023_icache_array.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/thor2023_icache_array.sv
// Set-associative I$ storage with a one-cycle tag-compare stage.
// It also runs a valid-bit clear sweep after reset and after invalidate-all.
module thor2023_icache_array #(
   parameter int unsigned WAYS = 4,
   parameter int unsigned SETS = 64,
   parameter int unsigned AWID = 32,
   parameter int unsigned CID  = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ce_i,
   input  logic [AWID-1:0]          ip_i,
   input  logic                     invall_i,
   input  logic                     wr_i,
   input  logic [$clog2(WAYS)-1:0]  way_i,
   input  logic [AWID-1:0]          line_vtag_i,
   input  logic [1:0]               line_v_i,
   input  logic [255:0]             line_data_i,
   input  logic                     snoop_v_i,
   input  logic [AWID-1:0]          snoop_adr_i,
   input  logic [3:0]               snoop_cid_i,
   output logic                     hit_o,
   output logic [AWID-1:0]          miss_adr_o,
   output logic [255:0]             line_o,
   output logic                     valid_o,
   output logic                     busy_o
);

   localparam int unsigned IDXW = $clog2(SETS);
   localparam int unsigned WAYW = $clog2(WAYS);
   localparam int unsigned TAGW = AWID - 5 - IDXW;
   localparam int unsigned LW   = 256;

   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [TAGW-1:0] tag_q  [WAYS][SETS];
   logic [1:0]      v_q    [WAYS][SETS];
   logic [LW-1:0]   data_q [WAYS][SETS];

   logic [0:0]      state_q, state_n;
   logic [IDXW-1:0] cnt_q, cnt_n;
   logic            hit_n, valid_n, busy_n;
   logic [AWID-1:0] adr_n;
   logic [LW-1:0]   line_n;

   logic [IDXW-1:0] l_idx, w_idx, s_idx;
   logic [TAGW-1:0] l_tag, w_tag;
   logic            snp;
   logic            lk_hit;
   logic [LW-1:0]   lk_line;
   logic [TAGW-1:0] e_tag;
   logic [1:0]      e_v;
   logic [LW-1:0]   e_data;
   logic            unused_c;

   assign l_idx = ip_i[5 +: IDXW];
   assign l_tag = ip_i[AWID-1 -: TAGW];
   assign w_idx = line_vtag_i[5 +: IDXW];
   assign w_tag = line_vtag_i[AWID-1 -: TAGW];
   assign s_idx = snoop_adr_i[5 +: IDXW];
   assign snp   = snoop_v_i && (snoop_cid_i != 4'(CID));
   assign unused_c = ^{line_vtag_i[4:0], snoop_adr_i[AWID-1:5+IDXW], snoop_adr_i[4:0]};

   // Tag compare on the set as it will look after this edge (write-first, snoop wins).
   always_comb begin
      lk_hit  = 1'b0;
      lk_line = '0;
      e_tag   = '0;
      e_v     = '0;
      e_data  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         e_tag  = tag_q[w][l_idx];
         e_v    = v_q[w][l_idx];
         e_data = data_q[w][l_idx];
         if (wr_i && (w_idx == l_idx) && (way_i == WAYW'(w))) begin
            e_tag  = w_tag;
            e_v    = line_v_i;
            e_data = line_data_i;
         end
         if (snp && (s_idx == l_idx))
            e_v = 2'b00;
         if ((e_tag == l_tag) && (e_v == 2'b11)) begin
            lk_hit  = 1'b1;
            lk_line = e_data;
         end
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      hit_n   = hit_o;
      valid_n = valid_o;
      busy_n  = busy_o;
      adr_n   = miss_adr_o;
      line_n  = line_o;
      case (state_q)
         ST_INIT: begin
            hit_n   = 1'b1;
            valid_n = 1'b0;
            busy_n  = 1'b1;
            if (cnt_q == IDXW'(SETS - 1)) begin
               state_n = ST_RUN;
               busy_n  = 1'b0;
            end else begin
               cnt_n = cnt_q + IDXW'(1);
            end
         end
         default: begin
            if (invall_i) begin
               state_n = ST_INIT;
               cnt_n   = '0;
               hit_n   = 1'b1;
               valid_n = 1'b0;
               busy_n  = 1'b1;
            end else if (ce_i) begin
               adr_n   = ip_i;
               valid_n = 1'b1;
               hit_n   = lk_hit;
               line_n  = lk_line;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_INIT;
         cnt_q      <= '0;
         hit_o      <= 1'b1;
         valid_o    <= 1'b0;
         busy_o     <= 1'b1;
         miss_adr_o <= '0;
         line_o     <= '0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         hit_o      <= hit_n;
         valid_o    <= valid_n;
         busy_o     <= busy_n;
         miss_adr_o <= adr_n;
         line_o     <= line_n;
      end
   end

   // Storage arrays; the snoop clear is issued after the refill so it takes precedence.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         for (int w = 0; w < WAYS; w++)
            v_q[w][cnt_q] <= 2'b00;
      end else if (!invall_i) begin
         if (wr_i) begin
            tag_q[way_i][w_idx]  <= w_tag;
            v_q[way_i][w_idx]    <= line_v_i;
            data_q[way_i][w_idx] <= line_data_i;
         end
         if (snp) begin
            for (int w = 0; w < WAYS; w++)
               v_q[w][s_idx] <= 2'b00;
         end
      end
   end

endmodule
